// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states, field widths,
// and the word-index to byte-address mapping.
package imem_boot_loader_pkg;

    localparam int HDR_W      = 16;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        WORD,
        CHK,
        DONE,
        ERROR
    } state_t;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] base, input logic [31:0] index);
        return base + (index << $clog2(WORD_BYTES));
    endfunction

endpackage

// File: rtl/loader_idle_timer.sv
// Idle-cycle watchdog: counts enabled cycles, pulses expired on the TIMEOUT_CYCLES-th one.
// Latency: expired is combinational from the count and enable, no extra cycle.
// Backpressure: none; clear has priority and restarts the count at zero.
module loader_idle_timer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expired = enable && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a sized, checksummed program image byte-by-byte and writes big-endian words to imem.
// Latency: write strobe one cycle after the 4th byte of a word; done/error one cycle after checksum.
// Backpressure: rx_ready high in every loading state (no bubbles), low in DONE/ERROR until start.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error,
    input  logic        start
);

    localparam int          IDX_W     = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

    state_t                state;
    logic [BYTE_W-1:0]     n_hi;
    logic [IDX_W-1:0]      n_words;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            byte_cnt;
    logic [3*BYTE_W-1:0]   shift_reg;
    logic [BYTE_W-1:0]     csum;
    logic [HDR_W-1:0]      n_hdr;
    logic                  xfer;
    logic                  timed;
    logic                  expired;

    assign rx_ready = (state != DONE) && (state != ERROR);
    assign xfer     = rx_valid && rx_ready;
    assign timed    = (state == HDR_LO) || (state == WORD) || (state == CHK);
    assign n_hdr    = {n_hi, rx_data};

    // Waiting for the first header byte is not a stall, so HDR_HI keeps the timer cleared.
    loader_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (xfer || !timed),
        .enable  (timed && !xfer),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HDR_HI;
            n_hi       <= '0;
            n_words    <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (xfer) begin
                        n_hi  <= rx_data;
                        state <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        if (n_hdr == '0) begin
                            state <= CHK;
                        end else if (32'(n_hdr) <= MAX_WORDS) begin
                            n_words <= IDX_W'(n_hdr);
                            state   <= WORD;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                WORD: begin
                    if (xfer) begin
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Write register is separate from the assembler so the next word can start now.
                        if (byte_cnt == LAST_BYTE) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {shift_reg, rx_data};
                            imem_addr  <= word_byte_addr(BASE_ADDR, 32'(idx));
                            idx        <= idx + 1'b1;
                            if (idx + IDX_W'(1) == n_words) begin
                                state <= CHK;
                            end
                        end else begin
                            shift_reg <= {shift_reg[2*BYTE_W-1:0], rx_data};
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        if (rx_data == csum) begin
                            state     <= DONE;
                            cpu_reset <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        state      <= HDR_HI;
                        idx        <= '0;
                        csum       <= '0;
                        byte_cnt   <= '0;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        cpu_reset  <= 1'b1;
                    end
                end
                default: state <= HDR_HI;
            endcase
            // expired already excludes a transfer this cycle, so a byte always beats the timeout.
            if (timed && expired) begin
                state      <= ERROR;
                load_error <= 1'b1;
            end
        end
    end

endmodule
